exu_cal: RTL and testbench

Shared calculation responder for the execute stage. It serves two requesters, the branch/jump unit (BJ port) and the integer ALU (AL port), over the cal val/rdy handshake. It arbitrates round-robin between them, executes XOR/CMP/ADD/SUB in one registered cycle and SLL/SRL/SRA iteratively at one bit per cycle, then returns the 32-bit result to the granted requester with a one-cycle rdy pulse.

---
 rtl/exu_cal_pkg.sv | 72 +++++++
 rtl/exu_cal_shf.sv | 45 ++++
 rtl/exu_cal.sv | 124 ++++++++++++
 tb/tb_exu_cal.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_cal_pkg.sv
// Shared types and helpers for the exu_cal calculation responder.
// Opb layout (LSB first): XOR, CMP, ADD, SUB, SLL, SRL, SRA, OPN1[32:0], OPN2[32:0].
package exu_cal_pkg;

  localparam int CAL_OPB_SIZE = 73;
  localparam int CAL_RES_W    = 32;

  typedef enum logic [1:0] {
    CAL_ST_IDLE = 2'd0,
    CAL_ST_RUN  = 2'd1,
    CAL_ST_DONE = 2'd2
  } cal_st_e;

  typedef enum logic {
    CAL_PORT_BJ = 1'b0,
    CAL_PORT_AL = 1'b1
  } cal_port_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_XOR  = 3'd1,
    OP_CMP  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_SRA  = 3'd7
  } cal_op_e;

  typedef struct packed {
    logic [32:0] opn2;
    logic [32:0] opn1;
    logic        op_sra;
    logic        op_srl;
    logic        op_sll;
    logic        op_sub;
    logic        op_add;
    logic        op_cmp;
    logic        op_xor;
  } cal_opb_t;

  // Several op bits may be set; the earliest in this chain wins.
  function automatic cal_op_e cal_decode(input cal_opb_t opb);
    cal_op_e op;
    if (opb.op_xor)      op = OP_XOR;
    else if (opb.op_cmp) op = OP_CMP;
    else if (opb.op_add) op = OP_ADD;
    else if (opb.op_sub) op = OP_SUB;
    else if (opb.op_sll) op = OP_SLL;
    else if (opb.op_srl) op = OP_SRL;
    else if (opb.op_sra) op = OP_SRA;
    else                 op = OP_NONE;
    return op;
  endfunction

  // Single-cycle results; CMP is a 33-bit signed compare so requesters choose
  // signed or unsigned semantics through how they extend the operands.
  function automatic logic [CAL_RES_W-1:0] cal_alu(input cal_op_e op,
                                                   input logic [32:0] a,
                                                   input logic [32:0] b);
    logic [CAL_RES_W-1:0] r;
    case (op)
      OP_XOR:  r = a[31:0] ^ b[31:0];
      OP_CMP:  r = {31'd0, ($signed(a) < $signed(b))};
      OP_ADD:  r = a[31:0] + b[31:0];
      OP_SUB:  r = a[31:0] - b[31:0];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exu_cal_shf.sv
// One-bit-per-cycle shifter; its registers also hold the latched operand
// and shift count for every accepted request.
module exu_cal_shf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic [4:0]  load_cnt,
  input  logic        step,
  input  logic        dir_right,
  input  logic        arith,
  output logic [31:0] sh_nxt,
  output logic        done
);

  logic [31:0] sh_q, sh_d;
  logic [4:0]  cnt_q, cnt_d;

  always_comb begin
    sh_nxt = dir_right ? {arith & sh_q[31], sh_q[31:1]} : {sh_q[30:0], 1'b0};
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    if (load) begin
      sh_d  = load_val;
      cnt_d = load_cnt;
    end else if (step) begin
      sh_d  = sh_nxt;
      cnt_d = cnt_q - 5'd1;
    end
  end

  // Flags the step that produces the final shifted value.
  assign done = (cnt_q == 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/exu_cal.sv
// Shared calculation responder: round-robin between BJ and AL requesters,
// single-cycle XOR/CMP/ADD/SUB, iterative SLL/SRL/SRA, one-cycle rdy pulse.
module exu_cal
  import exu_cal_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    hs_bj4cal_val,
  output logic                    hs_cal4bj_rdy,
  input  logic [CAL_OPB_SIZE-1:0] i_bj_opb,
  output logic [CAL_RES_W-1:0]    o_bj_res,
  input  logic                    hs_al4cal_val,
  output logic                    hs_cal4al_rdy,
  input  logic [CAL_OPB_SIZE-1:0] i_al_opb,
  output logic [CAL_RES_W-1:0]    o_al_res
);

  // Handshake: a requester raises val with a stable opb and holds both until
  // the single cycle its rdy is high; dropping val earlier aborts the request.

  cal_st_e              st_q, st_d;
  cal_port_e            grant_q, grant_d;
  cal_op_e              op_q, op_d;
  logic [CAL_RES_W-1:0] res_q, res_d;

  cal_opb_t  bj_opb, al_opb, sel_opb;
  cal_port_e pick;
  cal_op_e   sel_op;
  logic      req_any, sel_shift, grant_val, done_hit;
  logic      shf_load, shf_step, shf_done;
  logic [31:0] shf_nxt;

  assign bj_opb = i_bj_opb;
  assign al_opb = i_al_opb;

  always_comb begin
    req_any = hs_bj4cal_val | hs_al4cal_val;
    if (hs_bj4cal_val && hs_al4cal_val)
      pick = (grant_q == CAL_PORT_AL) ? CAL_PORT_BJ : CAL_PORT_AL;
    else if (hs_bj4cal_val)
      pick = CAL_PORT_BJ;
    else
      pick = CAL_PORT_AL;
    sel_opb   = (pick == CAL_PORT_BJ) ? bj_opb : al_opb;
    sel_op    = cal_decode(sel_opb);
    sel_shift = (sel_op == OP_SLL) || (sel_op == OP_SRL) || (sel_op == OP_SRA);
    grant_val = (grant_q == CAL_PORT_BJ) ? hs_bj4cal_val : hs_al4cal_val;
  end

  always_comb begin
    st_d     = st_q;
    grant_d  = grant_q;
    op_d     = op_q;
    res_d    = res_q;
    shf_load = 1'b0;
    shf_step = 1'b0;
    case (st_q)
      CAL_ST_IDLE: begin
        if (req_any) begin
          grant_d  = pick;
          op_d     = sel_op;
          shf_load = 1'b1;
          if (!sel_shift) begin
            res_d = cal_alu(sel_op, sel_opb.opn1, sel_opb.opn2);
            st_d  = CAL_ST_DONE;
          end else if (sel_opb.opn2[4:0] == 5'd0) begin
            res_d = sel_opb.opn1[31:0];
            st_d  = CAL_ST_DONE;
          end else begin
            st_d  = CAL_ST_RUN;
          end
        end
      end
      CAL_ST_RUN: begin
        if (!grant_val) begin
          st_d = CAL_ST_IDLE;
        end else begin
          shf_step = 1'b1;
          if (shf_done) begin
            res_d = shf_nxt;
            st_d  = CAL_ST_DONE;
          end
        end
      end
      CAL_ST_DONE: st_d = CAL_ST_IDLE;
      default:     st_d = CAL_ST_IDLE;
    endcase
  end

  exu_cal_shf u_shf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (shf_load),
    .load_val  (sel_opb.opn1[31:0]),
    .load_cnt  (sel_opb.opn2[4:0]),
    .step      (shf_step),
    .dir_right (op_q != OP_SLL),
    .arith     (op_q == OP_SRA),
    .sh_nxt    (shf_nxt),
    .done      (shf_done)
  );

  // rdy is gated by the live val so an abort in DONE suppresses the pulse.
  assign done_hit      = (st_q == CAL_ST_DONE) && grant_val;
  assign hs_cal4bj_rdy = done_hit && (grant_q == CAL_PORT_BJ);
  assign hs_cal4al_rdy = done_hit && (grant_q == CAL_PORT_AL);
  assign o_bj_res      = hs_cal4bj_rdy ? res_q : '0;
  assign o_al_res      = hs_cal4al_rdy ? res_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= CAL_ST_IDLE;
      grant_q <= CAL_PORT_AL;
      op_q    <= OP_NONE;
      res_q   <= '0;
    end else begin
      st_q    <= st_d;
      grant_q <= grant_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_exu_cal.sv
// Bench for exu_cal: directed literal cases plus randomized two-port traffic
// checked every cycle against a transaction-level model.
module tb_exu_cal;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bj_val = 1'b0, al_val = 1'b0;
  logic [72:0] bj_opb = '0, al_opb = '0;
  logic        bj_rdy, al_rdy;
  logic [31:0] bj_res, al_res;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] F_XOR = 7'h01, F_CMP = 7'h02, F_ADD = 7'h04, F_SUB = 7'h08;
  localparam logic [6:0] F_SLL = 7'h10, F_SRL = 7'h20, F_SRA = 7'h40;

  always #5 clk = ~clk;

  exu_cal dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hs_bj4cal_val (bj_val),
    .hs_cal4bj_rdy (bj_rdy),
    .i_bj_opb      (bj_opb),
    .o_bj_res      (bj_res),
    .hs_al4cal_val (al_val),
    .hs_cal4al_rdy (al_rdy),
    .i_al_opb      (al_opb),
    .o_al_res      (al_res)
  );

  // ---------------- reference rules ----------------
  function automatic logic [72:0] mk(input logic [6:0] op, input logic [32:0] a,
                                     input logic [32:0] b);
    return {b, a, op};
  endfunction

  function automatic logic [31:0] ref_res(input logic [72:0] opb);
    logic [6:0]  op;
    logic [32:0] a, b;
    logic signed [31:0] sa;
    op = opb[6:0];
    a  = opb[39:7];
    b  = opb[72:40];
    sa = a[31:0];
    if (op[0])      return a[31:0] ^ b[31:0];
    else if (op[1]) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else if (op[2]) return a[31:0] + b[31:0];
    else if (op[3]) return a[31:0] - b[31:0];
    else if (op[4]) return a[31:0] << b[4:0];
    else if (op[5]) return a[31:0] >> b[4:0];
    else if (op[6]) return sa >>> b[4:0];
    return 32'd0;
  endfunction

  function automatic int ref_lat(input logic [72:0] opb);
    if (opb[3:0] == 4'd0 && opb[6:4] != 3'd0 && opb[44:40] != 5'd0)
      return int'(opb[44:40]) + 1;
    return 1;
  endfunction

  // ---------------- transaction model ----------------
  // m_rem counts cycles left until the served port's rdy cycle.
  logic        m_busy, m_port, m_last;
  int          m_rem;
  logic [31:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_port = 1'b0; m_last = 1'b1; m_rem = 0; m_res = '0;
    end else if (m_busy) begin
      if (m_rem == 0)                          m_busy = 1'b0;
      else if (!(m_port ? al_val : bj_val))    m_busy = 1'b0;
      else                                     m_rem  = m_rem - 1;
    end else if (bj_val || al_val) begin
      m_port = (bj_val && al_val) ? ~m_last : al_val;
      m_last = m_port;
      m_busy = 1'b1;
      m_res  = ref_res(m_port ? al_opb : bj_opb);
      m_rem  = ref_lat(m_port ? al_opb : bj_opb) - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic exp_bj, exp_al;
    exp_bj = m_busy && !m_port && (m_rem == 0) && bj_val;
    exp_al = m_busy &&  m_port && (m_rem == 0) && al_val;
    check("model_bj_rdy", 32'(bj_rdy), 32'(exp_bj));
    check("model_bj_res", bj_res, exp_bj ? m_res : 32'd0);
    check("model_al_rdy", 32'(al_rdy), 32'(exp_al));
    check("model_al_res", al_res, exp_al ? m_res : 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit port, input bit v, input logic [72:0] opb);
    if (port) begin al_val = v; al_opb = opb; end
    else      begin bj_val = v; bj_opb = opb; end
  endtask

  function automatic logic [31:0] rdy_of(input bit port);
    return port ? 32'(al_rdy) : 32'(bj_rdy);
  endfunction

  function automatic logic [31:0] res_of(input bit port);
    return port ? al_res : bj_res;
  endfunction

  task automatic do_reset();
    bj_val = 1'b0; al_val = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    check("rst_bj_rdy", 32'(bj_rdy), 32'd0);
    check("rst_bj_res", bj_res, 32'd0);
    check("rst_al_rdy", 32'(al_rdy), 32'd0);
    check("rst_al_res", al_res, 32'd0);
    rst_n = 1'b1;
  endtask

  // Raise a request, verify rdy lands exactly at cycle lat with the literal result.
  task automatic run_req(input bit port, input logic [72:0] opb, input int lat,
                         input logic [31:0] exp, input string name);
    drive(port, 1'b1, opb);
    for (int c = 1; c <= lat; c++) begin
      tick();
      check({name, "_rdy"}, rdy_of(port), (c == lat) ? 32'd1 : 32'd0);
      if (c == lat) check({name, "_res"}, res_of(port), exp);
    end
    tick();
    check({name, "_rdy_end"}, rdy_of(port), 32'd0);
    drive(port, 1'b0, opb);
  endtask

  function automatic logic [72:0] rand_opb();
    logic [6:0]  op;
    logic [32:0] a, b;
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)      op = 7'(1 << r);
    else if (r < 9) op = 7'($urandom);
    else            op = 7'd0;
    a = {1'($urandom), 32'($urandom)};
    b = {1'($urandom), 32'($urandom)};
    if ($urandom_range(0, 3) == 0) a = 33'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) b = {b[32:5], 5'($urandom_range(0, 3))};
    return mk(op, a, b);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [72:0] r_opb[2];
    bit          hold[2];
    bit          rdy_prev[2];

    tick();
    do_reset();

    run_req(1'b0, mk(F_ADD, 33'h1000, 33'd4), 1, 32'h1004, "bj_add");
    run_req(1'b1, mk(F_CMP, 33'h1_FFFF_FFFF, 33'd1), 1, 32'd1, "al_cmp_s");
    run_req(1'b1, mk(F_CMP, 33'h0_FFFF_FFFF, 33'd1), 1, 32'd0, "al_cmp_u");
    run_req(1'b1, mk(F_SRA, 33'h8000_0000, 33'd4), 5, 32'hF800_0000, "al_sra4");
    run_req(1'b1, mk(F_SRA, 33'h8000_0000, 33'd0), 1, 32'h8000_0000, "al_sra0");
    run_req(1'b0, mk(F_XOR | F_ADD | F_SRA, 33'd6, 33'd3), 1, 32'd5, "bj_prio");
    run_req(1'b0, mk(F_SLL | F_SRL, 33'd3, 33'h1_FFFF_FFE2), 3, 32'd12, "bj_sll_hi");
    run_req(1'b1, mk(7'd0, 33'd9, 33'd9), 1, 32'd0, "al_noop");

    // Tie after reset: BJ first, then AL.
    do_reset();
    drive(1'b0, 1'b1, mk(F_XOR, 33'd5, 33'd5));
    drive(1'b1, 1'b1, mk(F_SUB, 33'd3, 33'd5));
    tick();
    check("tie_bj_rdy", 32'(bj_rdy), 32'd1);
    check("tie_bj_res", bj_res, 32'd0);
    check("tie_al_rdy1", 32'(al_rdy), 32'd0);
    tick();
    check("tie_al_rdy2", 32'(al_rdy), 32'd0);
    bj_val = 1'b0;
    tick();
    check("tie_al_rdy3", 32'(al_rdy), 32'd1);
    check("tie_al_res", al_res, 32'hFFFF_FFFE);
    tick();
    al_val = 1'b0;

    // Both ports requesting continuously: grants alternate BJ, AL, BJ...
    drive(1'b0, 1'b1, mk(F_XOR, 33'h0F, 33'hF0));
    drive(1'b1, 1'b1, mk(F_ADD, 33'd1, 33'd2));
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("alt_bj_rdy", 32'(bj_rdy), (c % 4 == 1) ? 32'd1 : 32'd0);
      check("alt_al_rdy", 32'(al_rdy), (c % 4 == 3) ? 32'd1 : 32'd0);
    end
    bj_val = 1'b0; al_val = 1'b0;

    // Abort: AL long shift dropped at cycle 10, pending BJ served by cycle 12.
    drive(1'b1, 1'b1, mk(F_SLL, 33'd1, 33'd31));
    for (int c = 1; c <= 13; c++) begin
      tick();
      check("abort_al_rdy", 32'(al_rdy), 32'd0);
      check("abort_bj_rdy", 32'(bj_rdy), (c == 12) ? 32'd1 : 32'd0);
      if (c == 12) check("abort_bj_res", bj_res, 32'd15);
      if (c == 2)  drive(1'b0, 1'b1, mk(F_ADD, 33'd7, 33'd8));
      if (c == 10) al_val = 1'b0;
    end
    bj_val = 1'b0;
    tick();

    // Reset mid-RUN.
    drive(1'b1, 1'b1, mk(F_SRL, 33'hFFFF_FFFF, 33'd20));
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("rstrun_al_rdy", 32'(al_rdy), 32'd0);
    check("rstrun_al_res", al_res, 32'd0);
    al_val = 1'b0;
    tick();
    rst_n = 1'b1;

    // Reset mid-DONE must kill a visible rdy pulse at once.
    drive(1'b1, 1'b1, mk(F_SRL, 33'hFFFF_FFFF, 33'd3));
    repeat (4) tick();
    check("rstdone_pre_rdy", 32'(al_rdy), 32'd1);
    check("rstdone_pre_res", al_res, 32'h1FFF_FFFF);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstdone_al_rdy", 32'(al_rdy), 32'd0);
    check("rstdone_al_res", al_res, 32'd0);
    al_val = 1'b0;
    tick();
    rst_n = 1'b1;
    run_req(1'b0, mk(F_ADD, 33'hFFFF_FFFF, 33'd1), 1, 32'd0, "post_rst_add");

    // Randomized traffic on both ports.
    hold[0] = 0; hold[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rdy_prev[0] = bj_rdy;
      rdy_prev[1] = al_rdy;
      tick();
      for (int p = 0; p < 2; p++) begin
        if (hold[p]) begin
          if (rdy_prev[p]) begin
            if ($urandom_range(0, 1) == 1) r_opb[p] = rand_opb();
            else hold[p] = 0;
          end else if ($urandom_range(0, 63) == 0) begin
            hold[p] = 0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          hold[p]  = 1;
          r_opb[p] = rand_opb();
        end
        drive(p[0], hold[p], r_opb[p]);
      end
    end
    bj_val = 1'b0; al_val = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
